mailbox_fifo: RTL

MAILBOX_FIFO -- requirements
Module: mailbox_fifo

---
 rtl/mailbox_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mailbox_fifo.sv
// Register-mapped mailbox FIFO with sticky error flags and a level/error interrupt.
// Read responses pass through a pending stage, so a reset arriving a cycle later still cancels them.
module mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_read,
  input  logic             reg_write,
  input  logic [1:0]       reg_address,
  input  logic [WIDTH-1:0] reg_data_in,
  output logic             reg_read_valid,
  output logic [WIDTH-1:0] reg_data_out,
  output logic             irq
);

  localparam int         PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C     = 5'(DEPTH);
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CONFIG = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [4:0]       count_q, count_d;
  logic             cfg_level_q, cfg_level_d, cfg_err_q, cfg_err_d;
  logic [4:0]       thr_q, thr_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             irq_q, irq_d;

  logic             push_s, empty_s, full_s;
  logic [WIDTH-1:0] rd_word_s;
  logic             unused_data_s;

  assign empty_s = (count_q == 5'd0);
  assign full_s  = (count_q == DEPTH_C);
  assign unused_data_s = ^reg_data_in;

  // Next-state logic: a read takes priority over a simultaneous write.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    cfg_level_d = cfg_level_q;
    cfg_err_d   = cfg_err_q;
    thr_d       = thr_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_s      = 1'b0;
    rd_word_s   = '0;
    pend_d      = 1'b0;
    pend_data_d = '0;

    if (reset) begin
      push_s = 1'b0;
    end else if (reg_read) begin
      pend_d = 1'b1;
      case (reg_address)
        ADDR_DATA: begin
          if (!empty_s) begin
            rd_word_s = mem_q[head_q];
            head_d    = head_q + PTR_W'(1);
            count_d   = count_q - 5'd1;
          end else begin
            unf_d = 1'b1;
          end
        end
        ADDR_CONFIG: begin
          rd_word_s[0]   = cfg_level_q;
          rd_word_s[1]   = cfg_err_q;
          rd_word_s[8:4] = thr_q;
        end
        ADDR_STATUS: begin
          rd_word_s[4:0] = count_q;
          rd_word_s[8]   = empty_s;
          rd_word_s[9]   = full_s;
          rd_word_s[16]  = ovf_q;
          rd_word_s[17]  = unf_q;
        end
        default: begin
          rd_word_s = '0;
        end
      endcase
      pend_data_d = rd_word_s;
    end else if (reg_write) begin
      case (reg_address)
        ADDR_DATA: begin
          if (!full_s) begin
            push_s  = 1'b1;
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_q + 5'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        ADDR_CONFIG: begin
          cfg_level_d = reg_data_in[0];
          cfg_err_d   = reg_data_in[1];
          thr_d       = reg_data_in[8:4];
        end
        ADDR_STATUS: begin
          ovf_d = ovf_q & ~reg_data_in[16];
          unf_d = unf_q & ~reg_data_in[17];
        end
        ADDR_CTRL: begin
          if (reg_data_in[0]) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = 5'd0;
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end

    valid_d = pend_q;
    data_d  = pend_q ? pend_data_q : '0;
    // Threshold above DEPTH can never be reached since count saturates at DEPTH.
    irq_d   = (cfg_level_q && (thr_q != 5'd0) && (count_q >= thr_q)) ||
              (cfg_err_q && (ovf_q || unf_q));
  end

  // Control and response state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 5'd0;
      cfg_level_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      thr_q       <= 5'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cfg_level_q <= cfg_level_d;
      cfg_err_q   <= cfg_err_d;
      thr_q       <= thr_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      irq_q       <= irq_d;
    end
  end

  // Storage array; contents survive reset and are only read when count is nonzero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[tail_q] <= reg_data_in;
    end
  end

  assign reg_read_valid = valid_q;
  assign reg_data_out   = data_q;
  assign irq            = irq_q;

endmodule
